// File: rtl/sub8_serial.sv
// Bit-serial a - b - bin, one full-subtractor cell, LSB first; optional saturation via SUB8_SERIAL_SAT_EN.
// Latency: out_valid rises WIDTH cycles after the accept edge; one op per WIDTH+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module sub8_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             ai, bi, d_bit, br_next;
    logic [WIDTH-1:0] res_next;

    assign ai       = a_sh_q[0];
    assign bi       = b_sh_q[0];
    assign d_bit    = ai ^ bi ^ br_q;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    // Result fills from the MSB end, so after WIDTH shifts bit 0 holds the LSB.
    assign res_next = {d_bit, res_q[WIDTH-1:1]};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SUB8_SERIAL_SAT_EN
                    diff_d = br_next ? '0 : res_next;
`else
                    diff_d = res_next;
`endif
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sub8_serial.sv
// Directed bench for sub8_serial: hand-computed vectors, latency, backpressure and reset.
module tb_sub8_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       bout;

    int total = 0;
    int bad   = 0;

    sub8_serial #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

`ifdef SUB8_SERIAL_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operand set from IDLE, check exact latency and result, then drain.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic bv_in, input logic [7:0] exp_mod, input logic exp_b);
        logic [7:0] exp_d;
        exp_d = (SAT && exp_b) ? 8'h00 : exp_mod;
        chk({tag, ".idle_rdy"}, in_ready, 1);
        a = av; b = bv; bin = bv_in; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; bin = ~bv_in;
        chk({tag, ".run_rdy"}, in_ready, 0);
        repeat (7) tick();
        chk({tag, ".early_vld"}, out_valid, 0);
        tick();
        chk({tag, ".vld"}, out_valid, 1);
        chk({tag, ".diff"}, diff, exp_d);
        chk({tag, ".bout"}, bout, exp_b);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".drained"}, out_valid, 0);
        chk({tag, ".hold_diff"}, diff, exp_d);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.diff", diff, 8'h00);
        chk("rst.bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("ff_00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
        tick();
        run_op("00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        tick();
        run_op("10_0f_b1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
        tick();
        run_op("80_7f_b1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        tick();
        run_op("00_00_b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        tick();
        run_op("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        tick();
        run_op("3c_5a", 8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1);
        tick();

        // Backpressure: hold DONE while in_valid toggles with other operands
        a = 8'h37; b = 8'h12; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("bp.vld", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 8'h01 + 8'(i); b = 8'hC0; bin = 1'b1;
            tick();
            chk("bp.hold_vld", out_valid, 1);
            chk("bp.hold_diff", diff, 8'h25);
            chk("bp.hold_bout", bout, 0);
            chk("bp.in_ready", in_ready, 0);
        end
        // Handshake and new operand in the same cycle: operand waits for IDLE
        a = 8'h09; b = 8'h02; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sim.idle", in_ready, 1);
        chk("sim.no_vld", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("sim.accepted", in_ready, 0);
        repeat (8) tick();
        chk("sim.vld", out_valid, 1);
        chk("sim.diff", diff, 8'h07);
        chk("sim.bout", bout, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // Reset four cycles into RUN discards the operation
        a = 8'h20; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid.in_ready", in_ready, 1);
        chk("mid.out_valid", out_valid, 0);
        chk("mid.diff", diff, 8'h00);
        chk("mid.bout", bout, 0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("mid.no_pulse", seen, 0);
        end
        run_op("post_rst", 8'h64, 8'h21, 1'b1, 8'h42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
